// File: rtl/alu_result_collector.sv
// Assembles {hi, lo} result bytes from the add/sub controller strobes into a FWFT FIFO.
// Optional ALU_RESULT_FLAGS_EN stores zero/negative flags per entry; otherwise flags are tied low.
//
// state   | meaning
// WAIT_HI | idle, expecting the high-byte strobe
// WAIT_LO | high byte held in hi_reg, expecting the low-byte strobe
module alu_result_collector #(
  parameter int DEPTH = 4,
  parameter int BW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     hi_strobe,
  input  logic                     lo_strobe,
  input  logic [BW-1:0]            outbus,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [2*BW-1:0]          result,
  output logic                     flag_zero,
  output logic                     flag_neg,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     seq_err,
  output logic                     ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {WAIT_HI = 1'b0, WAIT_LO = 1'b1} state_t;

  state_t          state;
  logic [BW-1:0]   hi_reg;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [2*BW-1:0] mem [DEPTH];
  logic [2*BW-1:0] push_data;
  logic            push_req;
  logic            push_ok;
  logic            pop;

  assign busy      = (state == WAIT_LO);
  assign push_req  = enable && (state == WAIT_LO) && lo_strobe && !hi_strobe;
  assign push_data = {hi_reg, outbus};
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push_req && ((count < FULL) || pop);
  assign result    = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT_HI;
      hi_reg  <= '0;
      seq_err <= 1'b0;
    end else if (!enable) begin
      state  <= WAIT_HI;
      hi_reg <= '0;
    end else if (hi_strobe && lo_strobe) begin
      seq_err <= 1'b1;
    end else if (hi_strobe) begin
      hi_reg <= outbus;
      state  <= WAIT_LO;
      if (state == WAIT_LO) seq_err <= 1'b1;
    end else if (lo_strobe) begin
      if (state == WAIT_HI) seq_err <= 1'b1;
      else                  state   <= WAIT_HI;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push_req && !push_ok) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

`ifdef ALU_RESULT_FLAGS_EN
  logic [1:0] flag_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push_ok) flag_mem[wr_ptr] <= {push_data[2*BW-1], (push_data == '0)};
  end

  assign flag_zero = out_valid && flag_mem[rd_ptr][0];
  assign flag_neg  = out_valid && flag_mem[rd_ptr][1];
`else
  assign flag_zero = 1'b0;
  assign flag_neg  = 1'b0;
`endif

endmodule
